// File: rtl/led_flash_sequencer_pkg.sv
// Shared mode encodings and step-rate derivation for the LED flash sequencer
// and the led_flasher rate math.
package led_flash_sequencer_pkg;

   localparam logic [1:0] MODE_IDLE     = 2'd0;
   localparam logic [1:0] MODE_ALL      = 2'd1;
   localparam logic [1:0] MODE_CHASE    = 2'd2;
   localparam logic [1:0] MODE_PINGPONG = 2'd3;

   // 64-bit intermediate: CLK_FREQ_HZ*1000 overflows 32 bits for real clocks
   function automatic int unsigned step_cycles(input longint clk_freq_hz,
                                               input longint step_rate_mhz);
      return 32'(clk_freq_hz * 64'sd1000 / step_rate_mhz);
   endfunction

endpackage

// File: rtl/led_flash_sequencer_btn_debouncer.sv
// Button conditioner: 2-flop synchronizer, stability-count debouncer and
// rising-edge press detector.
module btn_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic btn_in,
   output logic level_o,
   output logic press_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] stable_cnt;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync_p0    <= 1'b0;
         sync_p1    <= 1'b0;
         stable_cnt <= '0;
         level_o    <= 1'b0;
         press_o    <= 1'b0;
      end else begin
         sync_p0 <= btn_in;
         sync_p1 <= sync_p0;
         press_o <= 1'b0;
         // Any sample matching the accepted level restarts the stability run
         if (sync_p1 != level_o) begin
            if (stable_cnt == CNT_LAST) begin
               level_o    <= sync_p1;
               press_o    <= sync_p1;
               stable_cnt <= '0;
            end else begin
               stable_cnt <= stable_cnt + 1'b1;
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/led_flash_sequencer.sv
// Button-driven pattern sequencer that keeps a bank of led_flasher enables in
// step with the current display pattern via single-cycle toggle pulses.
module led_flash_sequencer
   import led_flash_sequencer_pkg::*;
#(
   parameter int NUM_LEDS        = 4,
   parameter int CLK_FREQ_HZ     = 50_000_000,
   parameter int STEP_RATE_mHz   = 2000,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                btn_in,
   output logic [NUM_LEDS-1:0] toggle_flash_o,
   output logic [NUM_LEDS-1:0] flash_en_o,
   output logic [1:0]          mode_o
);

   localparam int unsigned STEP_CYCLES = step_cycles(64'(CLK_FREQ_HZ), 64'(STEP_RATE_mHz));
   localparam int STEP_W = $clog2(STEP_CYCLES);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

   logic                btn_level;
   logic                btn_press;
   logic                press;
   logic [1:0]          mode;
   logic [STEP_W-1:0]   step_cnt;
   logic                running;
   logic                step;
   logic [POS_W-1:0]    pos;
   logic [POS_W-1:0]    pos_next;
   logic                dir_down;
   logic                dir_next;
   logic [NUM_LEDS-1:0] target_p0;
   logic [NUM_LEDS-1:0] shadow_p1;
   logic [NUM_LEDS-1:0] toggle_p1;

   btn_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debouncer (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .btn_in  (btn_in),
      .level_o (btn_level),
      .press_o (btn_press)
   );

   assign press   = btn_press & btn_level;
   assign running = (mode == MODE_CHASE) || (mode == MODE_PINGPONG);
   assign step    = running && (step_cnt == STEP_LAST);

   always_comb begin
      pos_next = pos;
      dir_next = dir_down;
      if (mode == MODE_CHASE) begin
         pos_next = (pos == LAST_POS) ? '0 : pos + 1'b1;
      end else if (NUM_LEDS > 1) begin
         // Flip on arrival at an end so the end position is shown only once
         pos_next = dir_down ? pos - 1'b1 : pos + 1'b1;
         if ((pos_next == LAST_POS) || (pos_next == '0)) dir_next = ~dir_down;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mode     <= MODE_IDLE;
         step_cnt <= '0;
         pos      <= '0;
         dir_down <= 1'b0;
      end else if (press) begin
         mode     <= mode + 1'b1;
         step_cnt <= '0;
         pos      <= '0;
         dir_down <= 1'b0;
      end else if (running) begin
         if (step) begin
            step_cnt <= '0;
            pos      <= pos_next;
            dir_down <= dir_next;
         end else begin
            step_cnt <= step_cnt + 1'b1;
         end
      end
   end

   // Stage p0: target mask decoded from mode and position
   always_comb begin
      target_p0 = '0;
      case (mode)
         MODE_ALL:                  target_p0 = '1;
         MODE_CHASE, MODE_PINGPONG: target_p0 = NUM_LEDS'(1) << pos;
         default:                   target_p0 = '0;
      endcase
   end

   // Stage p1: shadow of flasher enables; toggle pulses for every changed bit
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         shadow_p1 <= '0;
         toggle_p1 <= '0;
      end else begin
         toggle_p1 <= target_p0 ^ shadow_p1;
         shadow_p1 <= target_p0;
      end
   end

   assign toggle_flash_o = toggle_p1;
   assign flash_en_o     = shadow_p1;
   assign mode_o         = mode;

endmodule

// File: tb/tb_led_flash_sequencer.sv
// Self-checking bench for led_flash_sequencer against a pattern-level model.
module tb_led_flash_sequencer;

   localparam int N     = 4;
   localparam int DEB   = 4;
   localparam int STEP  = 10;

   logic       clk_in   = 1'b0;
   logic       rst_n_in = 1'b1;
   logic       btn_in   = 1'b0;
   logic [3:0] toggle_flash_o;
   logic [3:0] flash_en_o;
   logic [1:0] mode_o;

   int checks = 0;
   int errors = 0;

   led_flash_sequencer #(
      .NUM_LEDS       (N),
      .CLK_FREQ_HZ    (50),
      .STEP_RATE_mHz  (5000),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .btn_in        (btn_in),
      .toggle_flash_o(toggle_flash_o),
      .flash_en_o    (flash_en_o),
      .mode_o        (mode_o)
   );

   always #5 clk_in = ~clk_in;

   // Reference model: mode = presses mod 4, position derived from elapsed cycles
   bit         m_s1, m_s2, m_level, m_press;
   bit         hist[$];
   int         m_mode, m_elapsed;
   logic [3:0] m_flash, m_toggle;

   function automatic logic [3:0] model_target(input int md, input int el);
      int k, p;
      k = el / STEP;
      p = k % (2 * (N - 1));
      case (md)
         0:       return 4'b0000;
         1:       return 4'b1111;
         2:       return 4'(1 << (k % N));
         default: return 4'(1 << ((p < N) ? p : 2 * (N - 1) - p));
      endcase
   endfunction

   always @(posedge clk_in or negedge rst_n_in) begin : model
      logic [3:0] t;
      bit         all_diff;
      if (!rst_n_in) begin
         m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0;
         hist.delete();
         m_mode = 0; m_elapsed = 0;
         m_flash = '0; m_toggle = '0;
      end else begin
         t        = model_target(m_mode, m_elapsed);
         m_toggle = t ^ m_flash;
         m_flash  = t;
         if (m_press) begin
            m_mode    = (m_mode + 1) % 4;
            m_elapsed = 0;
         end else if (m_mode >= 2) begin
            m_elapsed++;
         end
         hist.push_back(m_s2);
         if (hist.size() > DEB) void'(hist.pop_front());
         m_press = 0;
         if (hist.size() == DEB) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
            if (all_diff) begin
               m_level = ~m_level;
               m_press = m_level;
            end
         end
         m_s2 = m_s1;
         m_s1 = btn_in;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time=%0t required end before it", $time);
      $fatal(1);
   end

   task automatic test_reset();
      btn_in = 1'b0;
      #3 rst_n_in = 1'b0;
      #1;
      checks++;
      if ({mode_o, flash_en_o, toggle_flash_o} !== 10'b0) begin
         errors++;
         $display("FAIL reset_values got mode=%b en=%b tog=%b required all zero", mode_o, flash_en_o, toggle_flash_o);
      end
      repeat (3) @(negedge clk_in);
      rst_n_in = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_in);
         checks++;
         if ({mode_o, flash_en_o, toggle_flash_o} !== 10'b0) begin
            errors++;
            $display("FAIL idle c=%0d got mode=%0d en=%b tog=%b required 0 0000 0000", c, mode_o, flash_en_o, toggle_flash_o);
         end
      end
   endtask

   task automatic test_clean_press();
      @(negedge clk_in);
      btn_in = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         @(negedge clk_in);
         if (e == 20) btn_in = 1'b0;
         checks++;
         if ({mode_o, flash_en_o, toggle_flash_o} !== {m_mode[1:0], m_flash, m_toggle}) begin
            errors++;
            $display("FAIL press_model e=%0d got %0d/%b/%b required %0d/%b/%b", e, mode_o, flash_en_o, toggle_flash_o, m_mode[1:0], m_flash, m_toggle);
         end
         if (e == 6 || e == 7) begin
            checks++;
            if (mode_o !== ((e == 7) ? 2'd1 : 2'd0)) begin
               errors++;
               $display("FAIL press_latency e=%0d got mode=%0d required %0d", e, mode_o, (e == 7) ? 1 : 0);
            end
         end
         if (e == 8 || e == 9) begin
            checks++;
            if ({flash_en_o, toggle_flash_o} !== ((e == 8) ? 8'hFF : 8'hF0)) begin
               errors++;
               $display("FAIL press_pulse e=%0d got en=%b tog=%b required en=1111 tog=%s", e, flash_en_o, toggle_flash_o, (e == 8) ? "1111" : "0000");
            end
         end
      end
   endtask

   task automatic test_bounce();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_in);
         checks++;
         if ({mode_o, toggle_flash_o} !== 6'b01_0000 ||
             {mode_o, flash_en_o, toggle_flash_o} !== {m_mode[1:0], m_flash, m_toggle}) begin
            errors++;
            $display("FAIL bounce c=%0d got mode=%0d tog=%b required mode=1 tog=0000", c, mode_o, toggle_flash_o);
         end
         btn_in = (c < 20) ? ((c / 2) % 2 == 0) : 1'b0;
      end
   endtask

   task automatic test_chase();
      logic [3:0] want_en, want_tog;
      @(negedge clk_in);
      btn_in = 1'b1;
      for (int e = 1; e <= 60; e++) begin
         @(negedge clk_in);
         if (e == 8) btn_in = 1'b0;
         checks++;
         if ({mode_o, flash_en_o, toggle_flash_o} !== {m_mode[1:0], m_flash, m_toggle}) begin
            errors++;
            $display("FAIL chase_model e=%0d got %0d/%b/%b required %0d/%b/%b", e, mode_o, flash_en_o, toggle_flash_o, m_mode[1:0], m_flash, m_toggle);
         end
         if (e >= 18 && e <= 48 && (e - 8) % 10 == 0) begin
            want_en  = 4'(1 << (((e - 8) / 10) % 4));
            want_tog = want_en | 4'(1 << (((e - 8) / 10 + 3) % 4));
            checks++;
            if ({flash_en_o, toggle_flash_o} !== {want_en, want_tog}) begin
               errors++;
               $display("FAIL chase_step e=%0d got en=%b tog=%b required en=%b tog=%b", e, flash_en_o, toggle_flash_o, want_en, want_tog);
            end
         end
      end
   endtask

   task automatic test_pingpong();
      int pp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      @(negedge clk_in);
      btn_in = 1'b1;
      for (int e = 1; e <= 100; e++) begin
         @(negedge clk_in);
         if (e == 8 || e == 90) btn_in = 1'b0;
         if (e == 80) btn_in = 1'b1;
         checks++;
         if ({mode_o, flash_en_o, toggle_flash_o} !== {m_mode[1:0], m_flash, m_toggle}) begin
            errors++;
            $display("FAIL pingpong_model e=%0d got %0d/%b/%b required %0d/%b/%b", e, mode_o, flash_en_o, toggle_flash_o, m_mode[1:0], m_flash, m_toggle);
         end
         if (e >= 8 && e <= 78 && (e - 8) % 10 == 0) begin
            checks++;
            if (flash_en_o !== 4'(1 << pp[(e - 8) / 10])) begin
               errors++;
               $display("FAIL pingpong_pos e=%0d got en=%b required pos %0d", e, flash_en_o, pp[(e - 8) / 10]);
            end
         end
         if (e == 87) begin
            checks++;
            if (mode_o !== 2'd0) begin
               errors++;
               $display("FAIL wrap_to_idle got mode=%0d required 0", mode_o);
            end
         end
         if (e == 88) begin
            checks++;
            if ({flash_en_o, toggle_flash_o} !== 8'b0000_0010) begin
               errors++;
               $display("FAIL idle_pulse got en=%b tog=%b required en=0000 tog=0010", flash_en_o, toggle_flash_o);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      @(negedge clk_in);
      btn_in = 1'b1;
      for (int e = 1; e <= 100; e++) begin
         @(negedge clk_in);
         if (e == 8 || e == 28) btn_in = 1'b0;
         if (e == 20) btn_in = 1'b1;
         if (mode_o == 2'd2 && flash_en_o == 4'b0100) begin
            found = 1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reset_mid_wait got en=%b mode=%0d required en=0100 in chase", flash_en_o, mode_o);
      end
      rst_n_in = 1'b0;
      #1;
      checks++;
      if ({mode_o, flash_en_o, toggle_flash_o} !== 10'b0) begin
         errors++;
         $display("FAIL reset_async got mode=%0d en=%b tog=%b required all zero", mode_o, flash_en_o, toggle_flash_o);
      end
      for (int c = 0; c < 33; c++) begin
         @(negedge clk_in);
         if (c == 2) rst_n_in = 1'b1;
         checks++;
         if ({mode_o, flash_en_o, toggle_flash_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_stay_idle c=%0d got mode=%0d en=%b tog=%b required all zero", c, mode_o, flash_en_o, toggle_flash_o);
         end
      end
   endtask

   task automatic test_random();
      int   hold;
      logic lvl = 1'b0;
      int   c   = 0;
      while (c < 600) begin
         hold = int'($urandom_range(1, 9));
         lvl  = ~lvl;
         repeat (hold) begin
            @(negedge clk_in);
            checks++;
            if ({mode_o, flash_en_o, toggle_flash_o} !== {m_mode[1:0], m_flash, m_toggle}) begin
               errors++;
               $display("FAIL random_model c=%0d got %0d/%b/%b required %0d/%b/%b", c, mode_o, flash_en_o, toggle_flash_o, m_mode[1:0], m_flash, m_toggle);
            end
            btn_in = lvl;
            c++;
         end
      end
      btn_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_chase();
      test_pingpong();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
